// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe-robot sensor path: bus widths, compass codes,
// conditioner state encoding and code-validity checks.
package pipe_pkg;

  localparam int WALL_W = 4;
  localparam int MTN_W  = 4;
  localparam int CMPS_W = 4;

  localparam logic [CMPS_W-1:0] DIR_N = 4'b1000;
  localparam logic [CMPS_W-1:0] DIR_E = 4'b0100;
  localparam logic [CMPS_W-1:0] DIR_S = 4'b0010;
  localparam logic [CMPS_W-1:0] DIR_W = 4'b0001;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SETTLE     = 2'd1;
  localparam logic [1:0] ST_HOLD       = 2'd2;
  localparam logic [1:0] ST_WAIT_CLEAR = 2'd3;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic is_zero_or_onehot(input logic [3:0] v);
    return (v & (v - 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/pipe_debounce_cnt.sv
// Wall-event debouncer: tracks the reference pattern and run length, and flags
// when the pattern has been stable long enough or collapsed back to zero.
module pipe_debounce_cnt
  import pipe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              active,
  input  logic [WALL_W-1:0] sample,
  output logic              stable,
  output logic              glitch,
  output logic [WALL_W-1:0] ref_pat
);

  logic [CNT_W-1:0] cnt;
  logic             same;

  assign same   = (sample == ref_pat);
  assign glitch = active && (sample == '0);
  assign stable = active && (sample != '0) && same &&
                  ((cnt + CNT_W'(1)) == CNT_W'(DEBOUNCE_CYCLES));

  // ref_pat is always loaded before it is consulted, so only the count is reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      ref_pat <= sample;
      cnt     <= CNT_W'(1);
    end else if (active && (sample != '0)) begin
      if (!same) begin
        ref_pat <= sample;
        cnt     <= CNT_W'(1);
      end else if (!stable) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_sensor_cond.sv
// Sensor conditioner in front of pipeFSM: samples raw buses, debounces wall events
// and hands out one validated snapshot per junction. Macro PIPE_SENSOR_EVTCNT_EN adds event counters.
module pipe_sensor_cond
  import pipe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WALL_W-1:0] wll_raw,
  input  logic [MTN_W-1:0]  mtn_raw,
  input  logic [CMPS_W-1:0] cmps_raw,
  input  logic              snap_ready,
  output logic [WALL_W-1:0] wll,
  output logic [MTN_W-1:0]  mtn_sensor,
  output logic [CMPS_W-1:0] cmps,
  output logic              snap_valid,
  output logic              cmps_err,
  output logic              overrun,
  output logic [7:0]        evt_cnt,
  output logic [7:0]        glitch_cnt
);

  localparam bit DIRECT_LOAD = (DEBOUNCE_CYCLES == 1);

  logic [WALL_W-1:0] s_wll;
  logic [MTN_W-1:0]  s_mtn;
  logic [CMPS_W-1:0] s_cmps;
  logic [1:0]        state;

  logic              idle_hit;
  logic              db_active;
  logic              db_stable;
  logic              db_glitch;
  logic [WALL_W-1:0] ref_pat;
  logic              load_fire;
  logic [WALL_W-1:0] load_wll;

  // Input sampling stage, free-running even while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      s_wll  <= '0;
      s_mtn  <= '0;
      s_cmps <= '0;
    end else begin
      s_wll  <= wll_raw;
      s_mtn  <= mtn_raw;
      s_cmps <= cmps_raw;
    end
  end

  assign idle_hit  = (state == ST_IDLE) && (s_wll != '0);
  assign db_active = en && (state == ST_SETTLE);
  assign load_fire = en && ((idle_hit && DIRECT_LOAD) || db_stable);
  assign load_wll  = (state == ST_IDLE) ? s_wll : ref_pat;

  pipe_debounce_cnt #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .load   (en && idle_hit),
    .active (db_active),
    .sample (s_wll),
    .stable (db_stable),
    .glitch (db_glitch),
    .ref_pat(ref_pat)
  );

  // Control FSM and snapshot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wll        <= '0;
      mtn_sensor <= '0;
      cmps       <= DIR_N;
      snap_valid <= 1'b0;
      cmps_err   <= 1'b0;
      overrun    <= 1'b0;
    end else if (!en) begin
      state      <= ST_IDLE;
      snap_valid <= 1'b0;
    end else begin
      if (load_fire) begin
        wll        <= load_wll;
        snap_valid <= 1'b1;
        mtn_sensor <= is_zero_or_onehot(s_mtn) ? s_mtn : '0;
        if (is_onehot(s_cmps)) cmps <= s_cmps;
        else                   cmps_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (s_wll != '0) state <= DIRECT_LOAD ? ST_HOLD : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (db_glitch)      state <= ST_IDLE;
          else if (db_stable) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if ((s_wll != '0) && (s_wll != wll)) overrun <= 1'b1;
          if (snap_ready) begin
            snap_valid <= 1'b0;
            state      <= ST_WAIT_CLEAR;
          end
        end
        ST_WAIT_CLEAR: begin
          if (s_wll == '0)       state   <= ST_IDLE;
          else if (s_wll != wll) overrun <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_SENSOR_EVTCNT_EN
  logic [7:0] evt_q;
  logic [7:0] glitch_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Statistics counters; frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q    <= '0;
      glitch_q <= '0;
    end else begin
      if (load_fire)            evt_q    <= sat_inc(evt_q);
      if (db_active && db_glitch) glitch_q <= sat_inc(glitch_q);
    end
  end

  assign evt_cnt    = evt_q;
  assign glitch_cnt = glitch_q;
`else
  assign evt_cnt    = '0;
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_sensor_cond.sv
// Directed bench for pipe_sensor_cond: debounce latency, glitch rejection,
// handshake, code validation, overrun, enable and reset behaviour.
module tb_pipe_sensor_cond;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [3:0] wll_raw = '0;
  logic [3:0] mtn_raw = '0;
  logic [3:0] cmps_raw = 4'b1000;
  logic       snap_ready = 1'b0;
  logic [3:0] wll, mtn_sensor, cmps;
  logic       snap_valid, cmps_err, overrun;
  logic [7:0] evt_cnt, glitch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PIPE_SENSOR_EVTCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_sensor_cond dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wll_raw   (wll_raw),
    .mtn_raw   (mtn_raw),
    .cmps_raw  (cmps_raw),
    .snap_ready(snap_ready),
    .wll       (wll),
    .mtn_sensor(mtn_sensor),
    .cmps      (cmps),
    .snap_valid(snap_valid),
    .cmps_err  (cmps_err),
    .overrun   (overrun),
    .evt_cnt   (evt_cnt),
    .glitch_cnt(glitch_cnt)
  );

  function automatic logic [7:0] ecnt(input int n);
    return CNT_ON ? 8'(n) : 8'd0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; snap_ready = 1'b0;
    wll_raw = '0; mtn_raw = '0; cmps_raw = 4'b1000;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic release_snap();
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    wll_raw = '0;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (wll !== 4'b0000) begin n_fail++; $display("FAIL rst_wll: got %b want 0000", wll); end
    n_checks++; if (mtn_sensor !== 4'b0000) begin n_fail++; $display("FAIL rst_mtn: got %b want 0000", mtn_sensor); end
    n_checks++; if (cmps !== 4'b1000) begin n_fail++; $display("FAIL rst_cmps: got %b want 1000", cmps); end
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", snap_valid); end
    n_checks++; if (cmps_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got err=%b ovr=%b want 0 0", cmps_err, overrun); end
    n_checks++; if (evt_cnt !== 8'd0 || glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d %0d want 0 0", evt_cnt, glitch_cnt); end
  endtask

  task automatic test_accept();
    do_reset();
    wll_raw = 4'b0110; cmps_raw = 4'b1000; mtn_raw = 4'b0001;
    tick(2);
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL acc_early: got %b want 0", snap_valid); end
    tick(1);
    n_checks++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL acc_valid: got %b want 1", snap_valid); end
    n_checks++; if (wll !== 4'b0110) begin n_fail++; $display("FAIL acc_wll: got %b want 0110", wll); end
    n_checks++; if (cmps !== 4'b1000) begin n_fail++; $display("FAIL acc_cmps: got %b want 1000", cmps); end
    n_checks++; if (mtn_sensor !== 4'b0001) begin n_fail++; $display("FAIL acc_mtn: got %b want 0001", mtn_sensor); end
    n_checks++; if (evt_cnt !== ecnt(1)) begin n_fail++; $display("FAIL acc_evt: got %0d want %0d", evt_cnt, ecnt(1)); end
    tick(7);
    n_checks++; if (snap_valid !== 1'b1 || wll !== 4'b0110) begin n_fail++; $display("FAIL acc_hold: got v=%b wll=%b want 1 0110", snap_valid, wll); end
  endtask

  task automatic test_glitch();
    do_reset();
    wll_raw = 4'b0011;
    tick(1);
    wll_raw = 4'b0000;
    tick(1);
    tick(1);
    n_checks++; if (glitch_cnt !== ecnt(1)) begin n_fail++; $display("FAIL gl_cnt: got %0d want %0d", glitch_cnt, ecnt(1)); end
    tick(3);
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL gl_valid: got %b want 0", snap_valid); end
    n_checks++; if (evt_cnt !== ecnt(0)) begin n_fail++; $display("FAIL gl_evt: got %0d want %0d", evt_cnt, ecnt(0)); end
    wll_raw = 4'b0101;
    tick(3);
    n_checks++; if (snap_valid !== 1'b1 || wll !== 4'b0101) begin n_fail++; $display("FAIL gl_idle: got v=%b wll=%b want 1 0101", snap_valid, wll); end
  endtask

  task automatic test_back_to_back();
    int highs;
    do_reset();
    wll_raw = 4'b0011;
    tick(3);
    n_checks++; if (snap_valid !== 1'b1 || wll !== 4'b0011) begin n_fail++; $display("FAIL b2b_first: got v=%b wll=%b want 1 0011", snap_valid, wll); end
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack: got %b want 0", snap_valid); end
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (snap_valid === 1'b1) highs++;
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL b2b_resnap: got %0d valid cycles want 0", highs); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b want 0", overrun); end
    wll_raw = 4'b0000;
    tick(2);
    wll_raw = 4'b0101;
    tick(2);
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got %b want 0", snap_valid); end
    tick(1);
    n_checks++; if (snap_valid !== 1'b1 || wll !== 4'b0101) begin n_fail++; $display("FAIL b2b_second: got v=%b wll=%b want 1 0101", snap_valid, wll); end
    n_checks++; if (evt_cnt !== ecnt(2)) begin n_fail++; $display("FAIL b2b_evt: got %0d want %0d", evt_cnt, ecnt(2)); end
  endtask

  task automatic test_validation();
    do_reset();
    wll_raw = 4'b1000; cmps_raw = 4'b0001; mtn_raw = 4'b0000;
    tick(3);
    n_checks++; if (cmps !== 4'b0001 || cmps_err !== 1'b0) begin n_fail++; $display("FAIL val_good: got cmps=%b err=%b want 0001 0", cmps, cmps_err); end
    release_snap();
    wll_raw = 4'b0010; cmps_raw = 4'b1100; mtn_raw = 4'b0101;
    tick(3);
    n_checks++; if (snap_valid !== 1'b1 || wll !== 4'b0010) begin n_fail++; $display("FAIL val_snap: got v=%b wll=%b want 1 0010", snap_valid, wll); end
    n_checks++; if (cmps !== 4'b0001) begin n_fail++; $display("FAIL val_cmps_keep: got %b want 0001", cmps); end
    n_checks++; if (cmps_err !== 1'b1) begin n_fail++; $display("FAIL val_err: got %b want 1", cmps_err); end
    n_checks++; if (mtn_sensor !== 4'b0000) begin n_fail++; $display("FAIL val_mtn_bad: got %b want 0000", mtn_sensor); end
    release_snap();
    wll_raw = 4'b0001; cmps_raw = 4'b0100; mtn_raw = 4'b0010;
    tick(3);
    n_checks++; if (cmps !== 4'b0100 || mtn_sensor !== 4'b0010) begin n_fail++; $display("FAIL val_next: got cmps=%b mtn=%b want 0100 0010", cmps, mtn_sensor); end
    n_checks++; if (cmps_err !== 1'b1) begin n_fail++; $display("FAIL val_sticky: got %b want 1", cmps_err); end
    do_reset();
    n_checks++; if (cmps_err !== 1'b0) begin n_fail++; $display("FAIL val_err_rst: got %b want 0", cmps_err); end
  endtask

  task automatic test_overrun_enable();
    do_reset();
    wll_raw = 4'b0110;
    tick(3);
    wll_raw = 4'b0101;
    tick(1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", overrun); end
    tick(1);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_checks++; if (wll !== 4'b0110 || snap_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_frozen: got wll=%b v=%b want 0110 1", wll, snap_valid); end
    en = 1'b0;
    tick(1);
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL en_drop: got %b want 0", snap_valid); end
    n_checks++; if (overrun !== 1'b1 || wll !== 4'b0110) begin n_fail++; $display("FAIL en_held: got ovr=%b wll=%b want 1 0110", overrun, wll); end
    en = 1'b1;
    tick(2);
    n_checks++; if (snap_valid !== 1'b1 || wll !== 4'b0101) begin n_fail++; $display("FAIL en_idle: got v=%b wll=%b want 1 0101", snap_valid, wll); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wll_raw = 4'b0110; cmps_raw = 4'b0100; mtn_raw = 4'b0100;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++; if (snap_valid !== 1'b0 || wll !== 4'b0000 || cmps !== 4'b1000) begin n_fail++; $display("FAIL rm_settle: got v=%b wll=%b cmps=%b want 0 0000 1000", snap_valid, wll, cmps); end
    tick(3);
    n_checks++; if (snap_valid !== 1'b1 || cmps !== 4'b0100 || mtn_sensor !== 4'b0100) begin n_fail++; $display("FAIL rm_reaccept: got v=%b cmps=%b mtn=%b want 1 0100 0100", snap_valid, cmps, mtn_sensor); end
    wll_raw = 4'b0101;
    tick(2);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL rm_ovr: got %b want 1", overrun); end
    rst = 1'b1; snap_ready = 1'b1;
    tick(1);
    rst = 1'b0; snap_ready = 1'b0;
    n_checks++; if (wll !== 4'b0000 || mtn_sensor !== 4'b0000 || cmps !== 4'b1000) begin n_fail++; $display("FAIL rm_hold_data: got wll=%b mtn=%b cmps=%b want 0000 0000 1000", wll, mtn_sensor, cmps); end
    n_checks++; if (snap_valid !== 1'b0 || overrun !== 1'b0 || cmps_err !== 1'b0) begin n_fail++; $display("FAIL rm_hold_ctl: got v=%b ovr=%b err=%b want 0 0 0", snap_valid, overrun, cmps_err); end
    n_checks++; if (evt_cnt !== 8'd0 || glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d %0d want 0 0", evt_cnt, glitch_cnt); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_glitch();
    test_back_to_back();
    test_validation();
    test_overrun_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
